// File: rtl/apb_requester.sv
// apb_requester: turns a valid/ready command stream into single APB4 transfers,
// returning one response per command with optional pready timeout.
module apb_requester #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic        TO_EN  = TIMEOUT_CYCLES != 0;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_done;
  logic          w_abort;

  assign cmd_ready = r_state == S_IDLE && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_done    = r_state == S_ACCESS && pready;
  // pready wins over the timeout in the same cycle
  assign w_abort   = r_state == S_ACCESS && !pready && TO_EN && r_cnt == C_LAST;
  assign psel      = r_state == S_SETUP || r_state == S_ACCESS;
  assign penable   = r_state == S_ACCESS;
  assign rsp_valid = r_state == S_RESP;

  always_comb begin
    w_next = r_state == S_IDLE   ? (w_accept ? S_SETUP : S_IDLE) :
             r_state == S_SETUP  ? S_ACCESS :
             r_state == S_ACCESS ? ((w_done || w_abort) ? S_RESP : S_ACCESS) :
                                   (rsp_ready ? S_IDLE : S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pstrb       <= '0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state != S_ACCESS || w_next != S_ACCESS) ? '0 :
                 (&r_cnt ? r_cnt : r_cnt + 1'b1);
      if (w_accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pstrb  <= cmd_write ? cmd_strb : '0;
        pwdata <= cmd_write ? cmd_wdata : '0;
      end
      if (w_done) begin
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed vectors against hand-computed APB timing and responses.
module tb_apb_requester;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [11:0] paddr;
  logic        pwrite, psel, penable;
  logic [3:0]  pstrb;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  int n_chk = 0;
  int n_err = 0;

  apb_requester #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_clr"}, rsp_valid, 0);
    chk({tag, "_idle_rdy"}, cmd_ready, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
    rsp_ready = 0; prdata = 0; pready = 1; pslverr = 0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);

    // single write, zero wait states
    issue(1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
    chk("w_setup_psel", psel, 1);
    chk("w_setup_pen", penable, 0);
    chk("w_setup_rdy", cmd_ready, 0);
    chk("w_setup_paddr", paddr, 12'h004);
    tick();
    chk("w_acc_pen", penable, 1);
    chk("w_acc_pwdata", pwdata, 32'hDEADBEEF);
    chk("w_acc_pstrb", pstrb, 4'hF);
    chk("w_acc_pwrite", pwrite, 1);
    tick();
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rsp_psel", psel, 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_rsp_err", rsp_slverr, 0);
    finish_rsp("w");

    // read with three wait states; prdata junk until the ready cycle
    pready = 0; prdata = 32'hFFFF0000;
    issue(1'b0, 12'h010, 32'hAAAAAAAA, 4'hF);
    chk("r_setup_pstrb", pstrb, 0);
    chk("r_setup_pwdata", pwdata, 0);
    chk("r_setup_pwrite", pwrite, 0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (penable) n++;
      if (k == 3) begin pready = 1; prdata = 32'h12345678; end
    end
    chk("r_access_cycles", n, 4);
    tick();
    chk("r_rsp_valid", rsp_valid, 1);
    chk("r_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("r_rsp_pen", penable, 0);
    finish_rsp("r");

    // write with slave error
    pready = 1; pslverr = 1; prdata = 32'h99999999;
    issue(1'b1, 12'h008, 32'h1, 4'h1);
    tick();
    tick();
    pslverr = 0;
    chk("e_rsp_err", rsp_slverr, 1);
    chk("e_rsp_to", rsp_timeout, 0);
    chk("e_rsp_rdata", rsp_rdata, 0);
    finish_rsp("e");

    // timeout: pready never asserts
    pready = 0; prdata = 32'h77777777;
    issue(1'b0, 12'h040, 32'h0, 4'h0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!penable) break;
      n++;
    end
    chk("t_access_cycles", n, 8);
    chk("t_rsp_valid", rsp_valid, 1);
    chk("t_rsp_err", rsp_slverr, 1);
    chk("t_rsp_to", rsp_timeout, 1);
    chk("t_rsp_rdata", rsp_rdata, 0);
    chk("t_psel", psel, 0);
    finish_rsp("t");

    // pready on the 8th ACCESS cycle beats the timeout
    prdata = 32'hCAFEF00D;
    issue(1'b0, 12'h044, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t8_pen", penable, 1);
      if (k == 7) pready = 1;
    end
    tick();
    chk("t8_rsp_valid", rsp_valid, 1);
    chk("t8_rsp_to", rsp_timeout, 0);
    chk("t8_rsp_err", rsp_slverr, 0);
    chk("t8_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    finish_rsp("t8");

    // response back-pressure with a pending command
    issue(1'b1, 12'h00C, 32'h11223344, 4'h3);
    tick();
    tick();
    cmd_write = 0; cmd_addr = 12'h020; cmd_wdata = 0; cmd_strb = 0; cmd_valid = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_psel", psel, 0);
      chk("bp_paddr", paddr, 12'h00C);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("bp_hs_rsp", rsp_valid, 0);
    chk("bp_hs_rdy", cmd_ready, 1);
    prdata = 32'h00000055;
    tick();
    cmd_valid = 0;
    chk("bp_next_psel", psel, 1);
    chk("bp_next_paddr", paddr, 12'h020);
    tick();
    tick();
    chk("bp_next_rdata", rsp_rdata, 32'h55);
    finish_rsp("bp");

    // reset in the middle of ACCESS
    pready = 0;
    issue(1'b1, 12'h0F0, 32'h5A5A5A5A, 4'hF);
    tick();
    chk("mr_acc_pen", penable, 1);
    rst = 1;
    tick();
    chk("mr_psel", psel, 0);
    chk("mr_pen", penable, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_paddr", paddr, 0);
    chk("mr_cmd_ready", cmd_ready, 0);
    rst = 0; pready = 1;
    #1;
    chk("mr_rel_rdy", cmd_ready, 1);
    tick();
    chk("mr_no_rsp", rsp_valid, 0);
    prdata = 32'h0BADCAFE;
    issue(1'b0, 12'h030, 32'h0, 4'h0);
    tick();
    tick();
    chk("mr_rd_valid", rsp_valid, 1);
    chk("mr_rd_rdata", rsp_rdata, 32'h0BADCAFE);
    finish_rsp("mr");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 requester (master) that converts a simple valid/ready command stream into single APB transfers.
- Drives the requester side of the team's APB interface: paddr/pwrite/psel/penable/pstrb/pwdata out; prdata/pready/pslverr in.
- Returns one response per command on a valid/ready response channel.
- Used as the bench/bus-bridge front end for register-mapped completers such as the GPIO controller.

Parameters:
ADDR_WIDTH, 12, width of cmd_addr/paddr
DATA_WIDTH, 32, width of data buses; pstrb width = DATA_WIDTH/8
TIMEOUT_CYCLES, 256, max ACCESS cycles waiting for pready before abort; 0 disables timeout

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
cmd_strb  input  DATA_WIDTH/8  write byte strobes
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_slverr  output  1  pslverr sampled, or timeout
rsp_timeout  output  1  transfer aborted by timeout
paddr  output  ADDR_WIDTH  APB address
pwrite  output  1  APB direction
psel  output  1  APB select
penable  output  1  APB enable
pstrb  output  DATA_WIDTH/8  APB strobes
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Reset (rst high at edge): state=IDLE; psel, penable, pwrite, paddr, pstrb, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, timeout counter all 0. cmd_ready=0 while rst high.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1 (combinational on state, gated by !rst). On cmd_valid&&cmd_ready, register addr/write/wdata/strb into the APB outputs and go to SETUP.
- On reads, pstrb=0 and pwdata=0 regardless of cmd inputs.
- SETUP (1 cycle): psel=1, penable=0; go to ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pstrb/pwdata stay stable throughout SETUP and ACCESS.
  - On pready=1: capture rsp_rdata = write ? 0 : prdata; rsp_slverr = pslverr; rsp_timeout=0. Drop psel/penable; go to RESP.
  - On pready=0: increment counter. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 on a pready=0 cycle, abort: drop psel/penable, rsp_rdata=0, rsp_slverr=1, rsp_timeout=1; go to RESP.
  - pready takes priority over timeout in the same cycle.
- RESP: rsp_valid=1, psel=penable=0, response fields held stable until rsp_ready=1; then clear rsp_valid and counter and go to IDLE.
- cmd_ready=0 in SETUP, ACCESS and RESP: one outstanding transfer only.
- Latency: command accepted at edge T -> SETUP cycle T+1 -> ACCESS from T+2. With pready=1 in the first ACCESS cycle, rsp_valid=1 at T+3. Minimum command-to-command spacing: 4 cycles.
- Wait states: each pready=0 cycle in ACCESS adds one cycle.
- Counter: width $clog2(TIMEOUT_CYCLES+1), saturating, reset on leaving ACCESS.
- psel never asserts in IDLE or RESP. penable asserts only in ACCESS, and only after exactly one SETUP cycle.
- prdata/pslverr are ignored except in an ACCESS cycle with pready=1.
- Reset mid-operation: next edge returns to IDLE with all outputs 0. The in-flight transfer is dropped and no response is generated.

Test Plan:
- Write 0x004 data 0xDEADBEEF strb 0xF, pready tied 1 -> SETUP at T+1 (psel=1,penable=0), ACCESS at T+2 (penable=1, pwdata=0xDEADBEEF, pstrb=0xF), rsp_valid at T+3 with rdata=0, slverr=0.
- Read 0x010 with strb input 0xF, completer inserts 3 wait states, prdata=0x12345678 -> pstrb=0 and pwdata=0 during transfer, ACCESS lasts 4 cycles, rsp_rdata=0x12345678.
- Write with pslverr=1 on the pready cycle -> rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYCLES=8, pready held 0 -> psel drops after exactly 8 ACCESS cycles; rsp_slverr=1, rsp_timeout=1, rdata=0. Repeat with pready=1 on the 8th cycle -> normal completion, no timeout.
- rsp_ready held 0 for 5 cycles, cmd_valid held 1 -> rsp fields stable, cmd_ready=0, psel=0. Next command accepted the cycle after the rsp handshake.
- Assert rst during ACCESS -> next cycle psel=penable=rsp_valid=0. After release, a fresh read completes normally.
